// File: rtl/multicycle_control.sv
// Multicycle RISC-V style main control FSM: Moore-decoded datapath controls,
// opcode latched in DECODE, and a retired-instruction counter.
module multicycle_control (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic [3:0]  state,
   output logic        pc_en,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic        mem_to_reg,
   output logic        pc_source,
   output logic        illegal,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [31:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_LD_WB    = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC_R   = 4'd6,
      S_ALU_WB   = 4'd7,
      S_BRANCH   = 4'd8,
      S_EXEC_I   = 4'd9,
      S_TRAP     = 4'd10
   } state_t;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   state_t      state_q, state_d;
   logic [6:0]  opc_q, opc_d;
   logic [31:0] count_q, count_d;
   logic        retire_s;
   logic        pc_en_s, ir_write_s, mem_read_s, mem_write_s, reg_write_s;

   // State, latched opcode and retire counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         opc_q   <= 7'd0;
         count_q <= 32'd0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         count_q <= count_d;
      end
   end

   // Next-state and Moore output decode; strobes are gated by reset below.
   always_comb begin
      state_d     = state_q;
      opc_d       = opc_q;
      retire_s    = 1'b0;
      pc_en_s     = 1'b0;
      ir_write_s  = 1'b0;
      mem_read_s  = 1'b0;
      mem_write_s = 1'b0;
      reg_write_s = 1'b0;
      alu_src_a   = 1'b0;
      mem_to_reg  = 1'b0;
      pc_source   = 1'b0;
      illegal     = 1'b0;
      alu_src_b   = 2'b00;
      alu_op      = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_read_s = 1'b1;
            alu_src_b  = 2'b01;
            ir_write_s = mem_ready;
            pc_en_s    = mem_ready;
            if (mem_ready) state_d = S_DECODE;
            else           state_d = S_FETCH;
         end
         S_DECODE: begin
            alu_src_b = 2'b10;
            opc_d     = opcode;
            case (opcode)
               OP_R:         state_d = S_EXEC_R;
               OP_I:         state_d = S_EXEC_I;
               OP_LD, OP_ST: state_d = S_MEM_ADDR;
               OP_BR:        state_d = S_BRANCH;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            // Uses the opcode captured in DECODE; the IR input may have moved on.
            if (opc_q == OP_LD) state_d = S_MEM_RD;
            else                state_d = S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read_s = 1'b1;
            if (mem_ready) state_d = S_LD_WB;
            else           state_d = S_MEM_RD;
         end
         S_LD_WB: begin
            reg_write_s = 1'b1;
            mem_to_reg  = 1'b1;
            retire_s    = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write_s = 1'b1;
            retire_s    = mem_ready;
            if (mem_ready) state_d = S_FETCH;
            else           state_d = S_MEM_WR;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
            state_d   = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write_s = 1'b1;
            retire_s    = 1'b1;
            state_d     = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_source = 1'b1;
            pc_en_s   = zero;
            retire_s  = 1'b1;
            state_d   = S_FETCH;
         end
         S_TRAP: begin
            illegal = 1'b1;
            state_d = S_TRAP;
         end
         default: state_d = S_FETCH;
      endcase
      count_d = retire_s ? (count_q + 32'd1) : count_q;
   end

   assign state       = state_q;
   assign instr_count = count_q;
   assign pc_en       = pc_en_s     & ~reset;
   assign ir_write    = ir_write_s  & ~reset;
   assign mem_read    = mem_read_s  & ~reset;
   assign mem_write   = mem_write_s & ~reset;
   assign reg_write   = reg_write_s & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control; inputs change and outputs are
// sampled on the falling clock edge.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic [3:0]  state;
   logic        pc_en, ir_write, mem_read, mem_write, reg_write;
   logic        alu_src_a, mem_to_reg, pc_source, illegal;
   logic [1:0]  alu_src_b, alu_op;
   logic [31:0] instr_count;

   int n_vec = 0;
   int n_err = 0;

   multicycle_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .state(state), .pc_en(pc_en), .ir_write(ir_write), .mem_read(mem_read),
      .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .mem_to_reg(mem_to_reg), .pc_source(pc_source), .illegal(illegal),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b1;
      cyc(); cyc();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_mem_read_forced", 32'(mem_read), 32'd0);
      chk("rst_pc_en_forced", 32'(pc_en), 32'd0);
      chk("rst_count", instr_count, 32'd0);
      reset = 1'b0; #1;
      chk("post_rst_mem_read", 32'(mem_read), 32'd1);

      // FETCH stalls while memory is not ready
      mem_ready = 1'b0; #1;
      chk("fetch_wait_ir_write", 32'(ir_write), 32'd0);
      chk("fetch_wait_pc_en", 32'(pc_en), 32'd0);
      cyc();
      chk("fetch_hold", 32'(state), 32'd0);

      // R-type: 0,1,6,7,0
      opcode = 7'b0110011; mem_ready = 1'b1; #1;
      chk("r_fetch_ir_write", 32'(ir_write), 32'd1);
      chk("r_fetch_src_b", 32'(alu_src_b), 32'd1);
      cyc(); chk("r_s1", 32'(state), 32'd1);
      chk("r_dec_src_b", 32'(alu_src_b), 32'd2);
      cyc(); chk("r_s6", 32'(state), 32'd6);
      chk("r_exec_alu_op", 32'(alu_op), 32'd2);
      chk("r_exec_src_a", 32'(alu_src_a), 32'd1);
      chk("r_exec_no_wr", 32'(reg_write), 32'd0);
      cyc(); chk("r_s7", 32'(state), 32'd7);
      chk("r_wb_reg_write", 32'(reg_write), 32'd1);
      cyc(); chk("r_s0", 32'(state), 32'd0);
      chk("r_fetch_reg_write", 32'(reg_write), 32'd0);
      chk("r_count", instr_count, 32'd1);

      // Load with two wait cycles; opcode changes in MEM_ADDR to test the latch
      opcode = 7'b0000011;
      cyc(); chk("ld_s1", 32'(state), 32'd1);
      cyc(); chk("ld_s2", 32'(state), 32'd2);
      opcode = 7'b0100011;
      cyc(); chk("ld_s3a", 32'(state), 32'd3);
      chk("ld_mem_read", 32'(mem_read), 32'd1);
      mem_ready = 1'b0;
      cyc(); chk("ld_s3b", 32'(state), 32'd3);
      cyc(); chk("ld_s3c", 32'(state), 32'd3);
      mem_ready = 1'b1;
      cyc(); chk("ld_s4", 32'(state), 32'd4);
      chk("ld_mem_to_reg", 32'(mem_to_reg), 32'd1);
      chk("ld_reg_write", 32'(reg_write), 32'd1);
      cyc(); chk("ld_s0", 32'(state), 32'd0);
      chk("ld_count", instr_count, 32'd2);

      // Two BEQs: taken then not taken
      opcode = 7'b1100011; zero = 1'b1;
      cyc(); cyc(); chk("beq1_s8", 32'(state), 32'd8);
      chk("beq1_pc_en", 32'(pc_en), 32'd1);
      chk("beq1_pc_source", 32'(pc_source), 32'd1);
      chk("beq1_alu_op", 32'(alu_op), 32'd1);
      cyc(); chk("beq1_s0", 32'(state), 32'd0);
      zero = 1'b0;
      cyc(); cyc(); chk("beq2_s8", 32'(state), 32'd8);
      chk("beq2_pc_en", 32'(pc_en), 32'd0);
      chk("beq2_pc_source", 32'(pc_source), 32'd1);
      cyc(); chk("beq_count", instr_count, 32'd4);

      // ADDI: 0,1,9,7,0
      opcode = 7'b0010011;
      cyc(); cyc(); chk("addi_s9", 32'(state), 32'd9);
      chk("addi_src_b", 32'(alu_src_b), 32'd2);
      cyc(); chk("addi_s7", 32'(state), 32'd7);
      cyc(); chk("addi_count", instr_count, 32'd5);

      // Store with one wait cycle
      opcode = 7'b0100011;
      cyc(); cyc(); cyc(); chk("sd_s5", 32'(state), 32'd5);
      chk("sd_mem_write", 32'(mem_write), 32'd1);
      mem_ready = 1'b0;
      cyc(); chk("sd_hold", 32'(state), 32'd5);
      chk("sd_hold_count", instr_count, 32'd5);
      mem_ready = 1'b1;
      cyc(); chk("sd_s0", 32'(state), 32'd0);
      chk("sd_count", instr_count, 32'd6);

      // Illegal opcode parks in TRAP until reset
      opcode = 7'b1111111;
      cyc(); cyc(); chk("trap_s10", 32'(state), 32'd10);
      for (int i = 0; i < 10; i++) begin
         mem_ready = 1'(i % 2);
         cyc();
         chk("trap_hold", 32'(state), 32'd10);
         chk("trap_illegal", 32'(illegal), 32'd1);
         chk("trap_no_read", 32'(mem_read), 32'd0);
      end
      reset = 1'b1;
      cyc(); reset = 1'b0; #1;
      chk("trap_rst_state", 32'(state), 32'd0);
      chk("trap_rst_illegal", 32'(illegal), 32'd0);
      chk("trap_rst_count", instr_count, 32'd0);

      // Reset during a stalled store: strobe drops at once, nothing retires
      mem_ready = 1'b1; opcode = 7'b0010011;
      cyc(); cyc(); cyc(); cyc();
      chk("pre_sd_count", instr_count, 32'd1);
      opcode = 7'b0100011;
      cyc(); cyc(); mem_ready = 1'b0;
      cyc(); chk("sdr_s5", 32'(state), 32'd5);
      reset = 1'b1; #1;
      chk("sdr_mem_write_forced", 32'(mem_write), 32'd0);
      cyc(); reset = 1'b0; #1;
      chk("sdr_state", 32'(state), 32'd0);
      chk("sdr_count", instr_count, 32'd0);

      // Counter wrap on an ADDI retirement
      force dut.count_q = 32'hFFFF_FFFF;
      cyc();
      release dut.count_q;
      mem_ready = 1'b1; opcode = 7'b0010011;
      cyc(); cyc(); cyc();
      chk("wrap_s7", 32'(state), 32'd7);
      chk("wrap_pre", instr_count, 32'hFFFF_FFFF);
      cyc();
      chk("wrap_count", instr_count, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port opcode, input, 7, instruction bits [6:0] from the instruction register, the same word the immediate generator decodes.
REQ-004 SHALL have port zero, input, 1, ALU zero flag.
REQ-005 SHALL have port mem_ready, input, 1, memory completion strobe for the current read or write.
REQ-006 SHALL have port state, output, 4, current FSM state encoding.
REQ-007 SHALL have the following 1-bit outputs: pc_en, ir_write, mem_read, mem_write, reg_write, alu_src_a (0=PC, 1=rs1), mem_to_reg (0=ALU, 1=memory), pc_source (0=ALU result, 1=ALUOut register), illegal.
REQ-008 SHALL have outputs alu_src_b (2 bits: 00=rs2, 01=constant 4, 10=imm) and alu_op (2 bits: 00=add, 01=sub, 10=funct-decoded).
REQ-009 SHALL have port instr_count, output, 32, count of retired instructions.

Function
REQ-010 SHALL encode states as FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, LD_WB=4, MEM_WR=5, EXEC_R=6, ALU_WB=7, BRANCH=8, EXEC_I=9, TRAP=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-011 SHALL decode outputs from the registered state (Moore), except for the mem_ready and zero gating stated below.
REQ-012 FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=0; ir_write and pc_en SHALL equal mem_ready; advance to DECODE only when mem_ready=1, else hold.
REQ-013 DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut); next state by opcode: 0110011->EXEC_R, 0010011->EXEC_I, 0000011 or 0100011->MEM_ADDR, 1100011->BRANCH, any other opcode->TRAP.
REQ-014 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10, then go to ALU_WB. EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=10, then go to ALU_WB.
REQ-015 ALU_WB: reg_write=1, mem_to_reg=0, then go to FETCH.
REQ-016 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next state is MEM_RD if the latched opcode is 0000011, else MEM_WR.
REQ-017 SHALL latch the opcode in DECODE, and MEM_ADDR SHALL use the latched copy, not the live input.
REQ-018 MEM_RD: mem_read=1; hold until mem_ready, then go to LD_WB. LD_WB: reg_write=1, mem_to_reg=1, then go to FETCH.
REQ-019 MEM_WR: mem_write=1; hold until mem_ready, then go to FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=1, pc_en=zero, then go to FETCH.
REQ-021 TRAP: all strobes=0, illegal=1; SHALL stay in TRAP until reset.
REQ-022 In every state not named above, every strobe and select SHALL be 0.
REQ-023 instr_count SHALL increment by 1 on the edge that leaves ALU_WB, LD_WB, BRANCH, or MEM_WR (MEM_WR only with mem_ready=1); it SHALL wrap from 0xFFFFFFFF to 0.
REQ-024 Latency with mem_ready held at 1: BEQ 3 cycles, R-type, ADDI and SD 4 cycles, LD 5 cycles; each cycle mem_ready is low in FETCH, MEM_RD or MEM_WR adds one cycle.
REQ-025 SHALL ignore mem_ready outside FETCH, MEM_RD and MEM_WR.

Reset
REQ-026 While reset=1, pc_en, ir_write, mem_read, mem_write and reg_write SHALL be forced to 0 combinationally, regardless of state.
REQ-027 On an edge with reset=1: state=FETCH, instr_count=0, illegal=0, latched opcode=0; this applies from any state, including mid-wait in MEM_RD or MEM_WR and TRAP, and abandons the in-flight access.
REQ-028 On the first cycle after reset deasserts, state=FETCH and mem_read=1.

Verification
REQ-029 Reset, then opcode=0110011 with mem_ready=1 -> states 0,1,6,7,0; reg_write=1 only in state 7; instr_count=1.
REQ-030 opcode=0000011 with mem_ready low for 2 cycles in MEM_RD -> states 0,1,2,3,3,3,4,0; mem_to_reg=1 in state 4; instr_count=1.
REQ-031 opcode=1100011 with zero=1, then a second BEQ with zero=0 -> pc_en=1 in the first BRANCH state and pc_en=0 in the second; pc_source=1 in both; instr_count=2.
REQ-032 opcode=1111111 -> DECODE goes to TRAP, illegal=1 and held for 10 cycles; reset -> state=FETCH, illegal=0, instr_count=0.
REQ-033 Assert reset while in MEM_WR with mem_ready=0 -> mem_write=0 in the same cycle; after the edge state=FETCH and no retire is counted.
REQ-034 Preload instr_count to 0xFFFFFFFF (via retirements or a forced value), retire one ADDI (0010011) -> instr_count=0.
